vram_arbiter: RTL and testbench

- Shares one synchronous video RAM port between three requesters: background tile fetch (BG), sprite list scan (SPR) and the main CPU.
- Request priority follows the raster window: active display, horizontal blank or vertical blank.
- Window is taken from the hbl/vbl outputs of the video timing generator.
- Sits between the timing generator, the tile/sprite fetch engines, the CPU bus and the VRAM.

---
 rtl/video_pkg.sv | 37 +++
 rtl/vram_arb_pick.sv | 45 ++++
 rtl/vram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types for the VRAM arbiter
// Purpose: grant, FSM state and raster window encodings, plus the window decoder.
// Ports: none (package).
package video_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_BG,
        GNT_SPR,
        GNT_CPU
    } grant_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        WIN_ACTIVE,
        WIN_HBL,
        WIN_VBL
    } window_t;

    // Vertical blank dominates: hbl pulses inside vblank are ignored.
    function automatic window_t decode_window(input logic hbl, input logic vbl);
        if (vbl) begin
            return WIN_VBL;
        end
        if (hbl) begin
            return WIN_HBL;
        end
        return WIN_ACTIVE;
    endfunction

endpackage

// File: rtl/vram_arb_pick.sv
// rtl/vram_arb_pick.sv - combinational priority picker for the VRAM arbiter
// Purpose: choose one requester from the current requests, raster window and
//          CPU starvation flag.
// Ports:
//   bg_req, spr_req, cpu_req  in   pending requests
//   window                    in   decoded raster window
//   starve                    in   CPU has waited the maximum number of grants
//   grant                     out  selected requester (GNT_NONE if no request)
module vram_arb_pick
    import video_pkg::*;
(
    input  logic    bg_req,
    input  logic    spr_req,
    input  logic    cpu_req,
    input  window_t window,
    input  logic    starve,
    output grant_t  grant
);

    always_comb begin
        grant = GNT_NONE;
        if (starve && cpu_req) begin
            grant = GNT_CPU;
        end else begin
            case (window)
                WIN_HBL: begin
                    if (spr_req)      grant = GNT_SPR;
                    else if (bg_req)  grant = GNT_BG;
                    else if (cpu_req) grant = GNT_CPU;
                end
                WIN_VBL: begin
                    if (cpu_req)      grant = GNT_CPU;
                    else if (spr_req) grant = GNT_SPR;
                    else if (bg_req)  grant = GNT_BG;
                end
                default: begin
                    if (bg_req)       grant = GNT_BG;
                    else if (spr_req) grant = GNT_SPR;
                    else if (cpu_req) grant = GNT_CPU;
                end
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - three-way VRAM port arbiter (BG fetch, sprite scan, CPU)
// Purpose: serialises single-word accesses from three requesters onto one
//          synchronous VRAM port, prioritised by raster window with a CPU
//          anti-starvation override.
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   hbl, vbl                            blanking from the timing generator
//   bg_req/bg_addr/bg_ack/bg_dout       background fetch read port
//   spr_req/spr_addr/spr_ack/spr_dout   sprite scan read port
//   cpu_req/cpu_we/cpu_addr/cpu_din/cpu_ack/cpu_dout   CPU read/write port
//   mem_cs/mem_we/mem_addr/mem_din/mem_dout            VRAM port
module vram_arbiter
    import video_pkg::*;
#(
    parameter int AW         = 14,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 2,
    parameter int CPU_STARVE = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hbl,
    input  logic          vbl,
    input  logic          bg_req,
    input  logic [AW-1:0] bg_addr,
    output logic          bg_ack,
    output logic [DW-1:0] bg_dout,
    input  logic          spr_req,
    input  logic [AW-1:0] spr_addr,
    output logic          spr_ack,
    output logic [DW-1:0] spr_dout,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int              SW         = $clog2(CPU_STARVE + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(CPU_STARVE);
    // WAIT spans MEM_LAT cycles in total; its last cycle captures mem_dout.
    localparam logic [2:0]      WAIT_LAST  = 3'(MEM_LAT - 1);

    arb_state_t    state;
    grant_t        gnt;
    grant_t        pick;
    logic          lat_we;
    logic [2:0]    wait_cnt;
    logic [SW-1:0] starve_cnt;
    logic          starve;
    logic [AW-1:0] pick_addr;

    assign starve = (starve_cnt == STARVE_MAX);

    vram_arb_pick u_pick (
        .bg_req  (bg_req),
        .spr_req (spr_req),
        .cpu_req (cpu_req),
        .window  (decode_window(hbl, vbl)),
        .starve  (starve),
        .grant   (pick)
    );

    always_comb begin
        pick_addr = bg_addr;
        case (pick)
            GNT_SPR: pick_addr = spr_addr;
            GNT_CPU: pick_addr = cpu_addr;
            default: pick_addr = bg_addr;
        endcase
    end

    // The VRAM strobes are registered on the IDLE->ISSUE edge so they are
    // high exactly during the ISSUE cycle and zero everywhere else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt        <= GNT_NONE;
            lat_we     <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            bg_ack     <= 1'b0;
            bg_dout    <= '0;
            spr_ack    <= 1'b0;
            spr_dout   <= '0;
            cpu_ack    <= 1'b0;
            cpu_dout   <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            bg_ack   <= 1'b0;
            spr_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            case (state)
                IDLE: begin
                    if (!cpu_req) begin
                        starve_cnt <= '0;
                    end
                    if (pick != GNT_NONE) begin
                        gnt      <= pick;
                        lat_we   <= (pick == GNT_CPU) && cpu_we;
                        mem_cs   <= 1'b1;
                        mem_we   <= (pick == GNT_CPU) && cpu_we;
                        mem_addr <= pick_addr;
                        mem_din  <= (pick == GNT_CPU) ? cpu_din : '0;
                        if (pick == GNT_CPU) begin
                            starve_cnt <= '0;
                        end else if (cpu_req && !starve) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        case (gnt)
                            GNT_BG: begin
                                bg_ack  <= 1'b1;
                                bg_dout <= mem_dout;
                            end
                            GNT_SPR: begin
                                spr_ack  <= 1'b1;
                                spr_dout <= mem_dout;
                            end
                            GNT_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!lat_we) begin
                                    cpu_dout <= mem_dout;
                                end
                            end
                            default: ;
                        endcase
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                DONE: begin
                    gnt   <= GNT_NONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;
    import video_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hbl, vbl;
    logic        bg_req, spr_req, cpu_req, cpu_we;
    logic [13:0] bg_addr, spr_addr, cpu_addr;
    logic [15:0] cpu_din;
    logic        bg_ack, spr_ack, cpu_ack;
    logic [15:0] bg_dout, spr_dout, cpu_dout;
    logic        mem_cs, mem_we;
    logic [13:0] mem_addr;
    logic [15:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    vram_arbiter #(.AW(14), .DW(16), .MEM_LAT(LAT), .CPU_STARVE(4)) dut (
        .clk(clk), .reset_n(reset_n), .hbl(hbl), .vbl(vbl),
        .bg_req(bg_req), .bg_addr(bg_addr), .bg_ack(bg_ack), .bg_dout(bg_dout),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_dout(spr_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: fixed pattern plus tracked writes, LAT-stage read pipeline.
    bit [15:0] wval [0:16383];
    bit        wvalid [0:16383];
    logic [15:0] pipe [LAT];

    function automatic logic [15:0] model_rd(input logic [13:0] a);
        if (wvalid[a]) return wval[a];
        if (a == 14'h0123) return 16'hBEEF;
        return {2'b00, a} ^ 16'hA5C3;
    endfunction

    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            wval[mem_addr]   <= mem_din;
            wvalid[mem_addr] <= 1'b1;
        end
        pipe[0] <= mem_cs ? model_rd(mem_addr) : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout = pipe[LAT-1];

    // Scoreboard
    typedef struct {
        grant_t      who;
        logic [15:0] data;
        int          at;
    } exp_t;
    exp_t exp_q[$];
    logic [15:0] exp_cpu_dout = 16'h0;

    task automatic expect_ack(input grant_t who, input logic [15:0] data, input int at);
        exp_q.push_back('{who, data, at});
        if (who == GNT_CPU) exp_cpu_dout = data;
    endtask

    logic cs_prev = 1'b0;
    always @(negedge clk) begin
        grant_t      who;
        logic [15:0] d;
        exp_t        e;
        cs_prev <= mem_cs;
        if (mem_cs) check("cs_one_cycle", {31'b0, cs_prev}, 0);
        if (mem_we) check("we_needs_cs", {31'b0, mem_cs}, 1);
        if (bg_ack || spr_ack || cpu_ack) begin
            check("single_ack", 32'(bg_ack) + 32'(spr_ack) + 32'(cpu_ack), 1);
            who = bg_ack ? GNT_BG : (spr_ack ? GNT_SPR : GNT_CPU);
            d   = bg_ack ? bg_dout : (spr_ack ? spr_dout : cpu_dout);
            if (exp_q.size() == 0) begin
                check("spurious_ack", {30'b0, who}, {30'b0, GNT_NONE});
            end else begin
                e = exp_q.pop_front();
                check("ack_who", {30'b0, who}, {30'b0, e.who});
                check("ack_data", {16'b0, d}, {16'b0, e.data});
                check("ack_cycle", cyc, e.at);
            end
        end
    end

    function automatic logic ack_of(input grant_t w);
        case (w)
            GNT_BG:  return bg_ack;
            GNT_SPR: return spr_ack;
            GNT_CPU: return cpu_ack;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_ack(input grant_t who, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack_of(who) && k < budget);
        if (!ack_of(who)) check("ack_timeout", {31'b0, ack_of(who)}, 1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int c;
    grant_t seq [10];

    initial begin
        reset_n = 1'b0; hbl = 1'b0; vbl = 1'b0;
        bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        bg_addr = '0; spr_addr = '0; cpu_addr = '0; cpu_din = '0;
        tick(3);
        check("rst_ctrl", {28'b0, bg_ack, spr_ack, cpu_ack, mem_cs}, 0);
        check("rst_mem", {2'b0, mem_addr, mem_din}, 0);
        check("rst_douts", {bg_dout | spr_dout, cpu_dout}, 0);
        reset_n = 1'b1;
        tick(2);

        // Single CPU read in vblank
        c = cyc; vbl = 1'b1; cpu_addr = 14'h0123; cpu_we = 1'b0; cpu_req = 1'b1;
        expect_ack(GNT_CPU, model_rd(14'h0123), c + 4);
        tick(1);
        check("rd_cs", {31'b0, mem_cs}, 1);
        check("rd_addr", {18'b0, mem_addr}, 32'h0123);
        check("rd_we", {31'b0, mem_we}, 0);
        tick(1);
        check("rd_cs_low", {31'b0, mem_cs}, 0);
        wait_ack(GNT_CPU, 20);
        cpu_req = 1'b0;
        tick(2);

        // CPU write, then read back
        c = cyc; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_din = 16'h5A5A; cpu_req = 1'b1;
        expect_ack(GNT_CPU, exp_cpu_dout, c + 4);
        tick(1);
        check("wr_cs", {31'b0, mem_cs}, 1);
        check("wr_we", {31'b0, mem_we}, 1);
        check("wr_din", {16'b0, mem_din}, 32'h5A5A);
        check("wr_addr", {18'b0, mem_addr}, 32'h3FFF);
        tick(1);
        check("wr_we_low", {31'b0, mem_we}, 0);
        check("wr_din_low", {16'b0, mem_din}, 0);
        wait_ack(GNT_CPU, 20);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick(2);
        c = cyc; cpu_addr = 14'h3FFF; cpu_req = 1'b1;
        expect_ack(GNT_CPU, 16'h5A5A, c + 4);
        wait_ack(GNT_CPU, 20);
        cpu_req = 1'b0;
        tick(3);

        // hblank: SPR > BG > CPU, starvation forces CPU after 4 grants
        c = cyc; vbl = 1'b0; hbl = 1'b1;
        bg_addr = 14'h0010; spr_addr = 14'h0200; cpu_addr = 14'h0300;
        bg_req = 1'b1; spr_req = 1'b1; cpu_req = 1'b1;
        expect_ack(GNT_SPR, model_rd(14'h0200), c + 4);
        expect_ack(GNT_SPR, model_rd(14'h0200), c + 9);
        expect_ack(GNT_SPR, model_rd(14'h0200), c + 14);
        expect_ack(GNT_BG,  model_rd(14'h0010), c + 19);
        expect_ack(GNT_CPU, model_rd(14'h0300), c + 24);
        wait_ack(GNT_SPR, 20);
        wait_ack(GNT_SPR, 20);
        wait_ack(GNT_SPR, 20);
        spr_req = 1'b0;
        wait_ack(GNT_BG, 20);
        wait_ack(GNT_CPU, 20);
        bg_req = 1'b0; cpu_req = 1'b0;
        tick(3);

        // vblank (hbl ignored): CPU > SPR > BG
        c = cyc; vbl = 1'b1; hbl = 1'b1;
        bg_req = 1'b1; spr_req = 1'b1; cpu_req = 1'b1;
        expect_ack(GNT_CPU, model_rd(14'h0300), c + 4);
        expect_ack(GNT_SPR, model_rd(14'h0200), c + 9);
        expect_ack(GNT_BG,  model_rd(14'h0010), c + 14);
        wait_ack(GNT_CPU, 20);
        cpu_req = 1'b0;
        wait_ack(GNT_SPR, 20);
        spr_req = 1'b0;
        wait_ack(GNT_BG, 20);
        bg_req = 1'b0;
        tick(3);

        // Starvation in active display: 4 BG then 1 CPU, repeating
        c = cyc; vbl = 1'b0; hbl = 1'b0;
        bg_addr = 14'h0040; cpu_addr = 14'h0050;
        bg_req = 1'b1; cpu_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            seq[k] = (k % 5 == 4) ? GNT_CPU : GNT_BG;
            expect_ack(seq[k], model_rd(seq[k] == GNT_CPU ? 14'h0050 : 14'h0040), c + 4 + 5 * k);
        end
        for (int k = 0; k < 10; k++) wait_ack(seq[k], 20);
        bg_req = 1'b0; cpu_req = 1'b0;
        tick(3);

        // Request dropped during ISSUE still completes
        c = cyc; bg_addr = 14'h0070; spr_addr = 14'h0080;
        bg_req = 1'b1; spr_req = 1'b1;
        expect_ack(GNT_BG,  model_rd(14'h0070), c + 4);
        expect_ack(GNT_SPR, model_rd(14'h0080), c + 9);
        tick(1);
        check("drop_issue_cs", {31'b0, mem_cs}, 1);
        bg_req = 1'b0;
        wait_ack(GNT_BG, 20);
        wait_ack(GNT_SPR, 20);
        spr_req = 1'b0;
        tick(3);

        // Reset mid-WAIT of a BG read aborts it
        c = cyc; bg_addr = 14'h0090; bg_req = 1'b1;
        tick(2);
        reset_n = 1'b0;
        #1;
        check("abort_ctrl", {28'b0, bg_ack, spr_ack, cpu_ack, mem_cs}, 0);
        check("abort_mem", {2'b0, mem_addr, mem_din}, 0);
        check("abort_douts", {bg_dout | spr_dout, cpu_dout}, 0);
        exp_cpu_dout = 16'h0;
        bg_req = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        c = cyc; vbl = 1'b1; cpu_addr = 14'h0123; cpu_req = 1'b1;
        expect_ack(GNT_CPU, model_rd(14'h0123), c + 4);
        tick(1);
        check("post_rst_cs", {31'b0, mem_cs}, 1);
        wait_ack(GNT_CPU, 20);
        cpu_req = 1'b0;
        tick(3);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
